// File: rtl/systolic_stream_array_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix engine.
// Holds the job FSM encoding, the flush-latency rule and the output narrowing.
package systolic_stream_array_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Cycles from the last accepted beat until the far-corner PE has settled.
    function automatic int flush_lat(input int rows, input int cols, input int pipe_lat);
        return (rows - 1) + (cols - 1) + pipe_lat;
    endfunction

    // Accumulators up to 64 bits wide; the caller keeps the low out_w bits.
    function automatic logic signed [63:0] narrow(input logic signed [63:0] v,
                                                  input int out_w, input bit sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        narrow = v;
        if (sat) begin
            if (v > hi)
                narrow = hi;
            else if (v < lo)
                narrow = lo;
        end
    endfunction

endpackage

// File: rtl/systolic_stream_array_mac_unit.sv
// Pipelined signed multiply-accumulate processing element.
// The product and its en/clr tags travel PIPE_LAT-1 stages before reaching the accumulator.
module mac_unit #(
    parameter int IP_WIDTH       = 8,
    parameter int OP_WIDTH       = 32,
    parameter int PIPE_LAT       = 3,
    parameter bit clr_load_first = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       clr,
    input  logic signed [IP_WIDTH-1:0] a,
    input  logic signed [IP_WIDTH-1:0] b,
    output logic signed [OP_WIDTH-1:0] acc
);

    logic signed [2*IP_WIDTH-1:0] prod_full;
    logic signed [OP_WIDTH-1:0]   prod;
    logic signed [OP_WIDTH-1:0]   s_prod;
    logic                         s_en;
    logic                         s_clr;

    assign prod_full = (2*IP_WIDTH)'(a) * (2*IP_WIDTH)'(b);
    assign prod      = OP_WIDTH'(prod_full);

    if (PIPE_LAT > 1) begin : g_pipe
        localparam int PS = PIPE_LAT - 1;
        logic signed [OP_WIDTH-1:0] p_q [PS];
        logic [PS-1:0]              en_q;
        logic [PS-1:0]              clr_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < PS; k++)
                    p_q[k] <= '0;
                en_q  <= '0;
                clr_q <= '0;
            end else begin
                p_q[0]   <= prod;
                en_q[0]  <= en;
                clr_q[0] <= clr;
                for (int k = 1; k < PS; k++) begin
                    p_q[k]   <= p_q[k-1];
                    en_q[k]  <= en_q[k-1];
                    clr_q[k] <= clr_q[k-1];
                end
            end
        end

        assign s_prod = p_q[PS-1];
        assign s_en   = en_q[PS-1];
        assign s_clr  = clr_q[PS-1];
    end else begin : g_direct
        assign s_prod = prod;
        assign s_en   = en;
        assign s_clr  = clr;
    end

    // Bubbles (en=0) leave the accumulator untouched; wrap-around is intended.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (s_en) begin
            if (s_clr)
                acc <= clr_load_first ? s_prod : '0;
            else
                acc <= acc + s_prod;
        end
    end

endmodule

// File: rtl/systolic_stream_array.sv
// Output-stationary ROWS x COLS systolic array computing C = X^T * W over k_len beats.
// ROWS and COLS must both be at least 2.
module systolic_stream_array
    import systolic_stream_array_pkg::*;
#(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int IP_WIDTH  = 8,
    parameter int OP_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int SAT_EN    = 1,
    parameter int PIPE_LAT  = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [15:0]               k_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*IP_WIDTH-1:0]  input_vec,
    input  logic [COLS*IP_WIDTH-1:0]  weight_vec,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*OUT_WIDTH-1:0] out_row,
    output logic [$clog2(ROWS)-1:0]   out_row_idx,
    output logic                      busy,
    output logic                      done,
    output logic [31:0]               cycles_count,
    output state_t                    dbg_state
);

    localparam int FL    = flush_lat(ROWS, COLS, PIPE_LAT);
    localparam int IDX_W = $clog2(ROWS);
    localparam int FC_W  = $clog2(FL + 1);

    state_t               state;
    state_t               state_next;
    logic [15:0]          k_reg;
    logic [15:0]          beat_cnt;
    logic [FC_W-1:0]      flush_cnt;
    logic [IDX_W-1:0]     row_idx;
    logic                 rst;
    logic                 start_acc;
    logic                 beat;
    logic                 first_beat;
    logic                 last_beat;
    logic                 row_hs;
    logic                 last_row_hs;

    logic signed [IP_WIDTH-1:0] a_tap   [ROWS][COLS];
    logic signed [IP_WIDTH-1:0] b_tap   [ROWS][COLS];
    logic                       en_tap  [ROWS][COLS];
    logic                       clr_tap [ROWS][COLS];
    logic signed [OP_WIDTH-1:0] acc     [ROWS][COLS];

    assign rst = ~rst_n;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // in_ready depends only on state, and out_row/out_row_idx hold until out_ready.
    assign start_acc   = (state == ST_IDLE) && start && (k_len != 16'd0);
    assign beat        = (state == ST_LOAD) && in_valid;
    assign first_beat  = beat && (beat_cnt == 16'd0);
    assign last_beat   = beat && (beat_cnt == k_reg - 16'd1);
    assign row_hs      = (state == ST_DRAIN) && out_ready;
    assign last_row_hs = row_hs && (row_idx == IDX_W'(ROWS - 1));

    assign in_ready    = (state == ST_LOAD);
    assign out_valid   = (state == ST_DRAIN);
    assign busy        = (state != ST_IDLE);
    assign out_row_idx = row_idx;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_acc)                    state_next = ST_LOAD;
            ST_LOAD:  if (last_beat)                    state_next = ST_FLUSH;
            ST_FLUSH: if (flush_cnt == FC_W'(FL - 1))   state_next = ST_DRAIN;
            ST_DRAIN: if (last_row_hs)                  state_next = ST_IDLE;
            default:                                    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg        <= '0;
            beat_cnt     <= '0;
            flush_cnt    <= '0;
            row_idx      <= '0;
            cycles_count <= '0;
            done         <= 1'b0;
        end else begin
            done <= last_row_hs;
            if (start_acc) begin
                k_reg        <= k_len;
                beat_cnt     <= '0;
                cycles_count <= '0;
            end else if (busy)
                cycles_count <= cycles_count + 32'd1;
            if (beat)
                beat_cnt <= beat_cnt + 16'd1;
            if (state == ST_FLUSH)
                flush_cnt <= flush_cnt + FC_W'(1);
            else
                flush_cnt <= '0;
            if (row_hs)
                row_idx <= last_row_hs ? '0 : row_idx + IDX_W'(1);
        end
    end

    // Row i carries X element i plus en/clr; PE[i][j] taps it after i+j cycles.
    for (genvar i = 0; i < ROWS; i++) begin : g_row_line
        localparam int LEN = i + COLS - 1;
        logic signed [IP_WIDTH-1:0] a_q [LEN];
        logic [LEN-1:0]             en_q;
        logic [LEN-1:0]             clr_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < LEN; k++)
                    a_q[k] <= '0;
                en_q  <= '0;
                clr_q <= '0;
            end else begin
                a_q[0]   <= input_vec[(i+1)*IP_WIDTH-1 -: IP_WIDTH];
                en_q[0]  <= beat;
                clr_q[0] <= first_beat;
                for (int k = 1; k < LEN; k++) begin
                    a_q[k]   <= a_q[k-1];
                    en_q[k]  <= en_q[k-1];
                    clr_q[k] <= clr_q[k-1];
                end
            end
        end

        for (genvar j = 0; j < COLS; j++) begin : g_tap
            if (i + j == 0) begin : g_head
                assign a_tap[i][j]   = input_vec[(i+1)*IP_WIDTH-1 -: IP_WIDTH];
                assign en_tap[i][j]  = beat;
                assign clr_tap[i][j] = first_beat;
            end else begin : g_reg
                assign a_tap[i][j]   = a_q[i+j-1];
                assign en_tap[i][j]  = en_q[i+j-1];
                assign clr_tap[i][j] = clr_q[i+j-1];
            end
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col_line
        localparam int LEN = j + ROWS - 1;
        logic signed [IP_WIDTH-1:0] b_q [LEN];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k < LEN; k++)
                    b_q[k] <= '0;
            end else begin
                b_q[0] <= weight_vec[(j+1)*IP_WIDTH-1 -: IP_WIDTH];
                for (int k = 1; k < LEN; k++)
                    b_q[k] <= b_q[k-1];
            end
        end

        for (genvar i = 0; i < ROWS; i++) begin : g_tap
            if (i + j == 0) begin : g_head
                assign b_tap[i][j] = weight_vec[(j+1)*IP_WIDTH-1 -: IP_WIDTH];
            end else begin : g_reg
                assign b_tap[i][j] = b_q[i+j-1];
            end
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_pe_row
        for (genvar j = 0; j < COLS; j++) begin : g_pe_col
            mac_unit #(
                .IP_WIDTH       (IP_WIDTH),
                .OP_WIDTH       (OP_WIDTH),
                .PIPE_LAT       (PIPE_LAT),
                .clr_load_first (1'b1)
            ) u_pe (
                .clk (clk),
                .rst (rst),
                .en  (en_tap[i][j]),
                .clr (clr_tap[i][j]),
                .a   (a_tap[i][j]),
                .b   (b_tap[i][j]),
                .acc (acc[i][j])
            );
        end
    end

    // Accumulators are quiescent throughout DRAIN, so the row can be read directly.
    always_comb begin
        out_row = '0;
        if (state == ST_DRAIN) begin
            for (int j = 0; j < COLS; j++)
                out_row[j*OUT_WIDTH +: OUT_WIDTH] =
                    OUT_WIDTH'(narrow(64'(acc[row_idx][j]), OUT_WIDTH, SAT_EN != 0));
        end
    end

endmodule

// File: tb/tb_systolic_stream_array.sv
// Bench for systolic_stream_array: 4x4 array, saturating and truncating instances side by side.
`timescale 1ns/1ps
module tb_systolic_stream_array;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int IPW  = 8;
    localparam int OUTW = 16;
    localparam int FL   = (ROWS - 1) + (COLS - 1) + 3;
    localparam int RW   = COLS * OUTW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       k_len = '0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [ROWS*IPW-1:0] input_vec = '0;
    logic [COLS*IPW-1:0] weight_vec = '0;
    logic              in_ready, out_valid, busy, done;
    logic              in_ready_t, out_valid_t, busy_t, done_t;
    logic [RW-1:0]     out_row, out_row_t;
    logic [1:0]        out_row_idx, out_row_idx_t;
    logic [31:0]       cycles_count, cycles_count_t;
    logic [1:0]        dbg_state, dbg_state_t;

    int n_checks = 0;
    int n_fail   = 0;
    int xm [16][ROWS];
    int wm [16][COLS];
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_t_q[$];
    logic [31:0]   exp_cycles = '0;
    logic [31:0]   cc_plain, cc_bubble, cc_tmp;

    systolic_stream_array #(.ROWS(ROWS), .COLS(COLS), .IP_WIDTH(IPW), .OP_WIDTH(32),
                            .OUT_WIDTH(OUTW), .SAT_EN(1), .PIPE_LAT(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .input_vec(input_vec), .weight_vec(weight_vec),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_row_idx(out_row_idx),
        .busy(busy), .done(done), .cycles_count(cycles_count), .dbg_state(dbg_state));

    systolic_stream_array #(.ROWS(ROWS), .COLS(COLS), .IP_WIDTH(IPW), .OP_WIDTH(32),
                            .OUT_WIDTH(OUTW), .SAT_EN(0), .PIPE_LAT(3)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready_t), .input_vec(input_vec), .weight_vec(weight_vec),
        .out_valid(out_valid_t), .out_ready(out_ready), .out_row(out_row_t), .out_row_idx(out_row_idx_t),
        .busy(busy_t), .done(done_t), .cycles_count(cycles_count_t), .dbg_state(dbg_state_t));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // C[i][j] = sum_k X[k][i]*W[k][j], wrapped to 32 bits, then clamped or truncated.
    task automatic build_expected(input int k);
        exp_q.delete();
        exp_t_q.delete();
        for (int i = 0; i < ROWS; i++) begin
            logic [RW-1:0] rs, rt;
            rs = '0;
            rt = '0;
            for (int j = 0; j < COLS; j++) begin
                longint sum;
                int wrapped, sat;
                sum = 0;
                for (int kk = 0; kk < k; kk++)
                    sum += longint'(xm[kk][i]) * longint'(wm[kk][j]);
                wrapped = int'(sum);
                if (wrapped > 32767) sat = 32767;
                else if (wrapped < -32768) sat = -32768;
                else sat = wrapped;
                rs[j*OUTW +: OUTW] = 16'(sat);
                rt[j*OUTW +: OUTW] = 16'(wrapped);
            end
            exp_q.push_back(rs);
            exp_t_q.push_back(rt);
        end
    endtask

    task automatic set_identity_job();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < ROWS; i++) xm[k][i] = (k == i) ? 1 : 0;
            for (int j = 0; j < COLS; j++) wm[k][j] = 4 * k + j;
        end
    endtask

    task automatic drive_beat(input int b);
        for (int i = 0; i < ROWS; i++) input_vec[i*IPW +: IPW] = 8'(xm[b][i]);
        for (int j = 0; j < COLS; j++) weight_vec[j*IPW +: IPW] = 8'(wm[b][j]);
    endtask

    // vmode: 0 = in_valid held high, 1 = toggling starting low, 2 = random.
    task automatic run_job(input int k, input int vmode, input int stall_row, input int stall_len,
                           input bit noise, output logic [31:0] cc);
        int load_cycles, beats, lat, drain_cycles, stalls, row;
        bit seen;
        logic [RW-1:0] er, et;
        build_expected(k);
        start = 1'b1;
        k_len = 16'(k);
        @(posedge clk); #1;
        start = 1'b0;
        load_cycles = 0;
        beats = 0;
        while (beats < k && load_cycles < 200) begin
            if (vmode == 0) in_valid = 1'b1;
            else if (vmode == 1) in_valid = ((load_cycles % 2) == 1);
            else in_valid = 1'($urandom_range(0, 1));
            if (in_valid) drive_beat(beats);
            else begin input_vec = $urandom(); weight_vec = $urandom(); end
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_in_ready: got %0b expected 1 (cycle %0d)", in_ready, load_cycles);
            end
            if (in_valid) beats++;
            load_cycles++;
            @(posedge clk); #1;
        end
        in_valid = noise;
        input_vec = $urandom();
        weight_vec = $urandom();
        lat = 0;
        seen = 0;
        while (!seen && lat < 40) begin
            start = (noise && lat == 3);
            k_len = noise ? 16'd5 : 16'(k);
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
            else begin lat++; @(posedge clk); #1; end
        end
        start = 1'b0;
        if (!seen) @(negedge clk);
        n_checks++;
        if (!seen || lat != FL) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles (seen=%0b) expected %0d", lat, seen, FL);
        end
        row = 0;
        stalls = 0;
        drain_cycles = 0;
        while (row < ROWS && drain_cycles < 60) begin
            er = (exp_q.size() > 0) ? exp_q[0] : '0;
            et = (exp_t_q.size() > 0) ? exp_t_q[0] : '0;
            n_checks++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid: got %0b expected 1", out_valid); end
            n_checks++;
            if (out_row_idx !== 2'(row)) begin n_fail++; $display("FAIL row_idx: got %0d expected %0d", out_row_idx, row); end
            n_checks++;
            if (out_row !== er) begin n_fail++; $display("FAIL row_sat[%0d]: got %h expected %h", row, out_row, er); end
            n_checks++;
            if (out_row_t !== et) begin n_fail++; $display("FAIL row_trunc[%0d]: got %h expected %h", row, out_row_t, et); end
            n_checks++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL early_done: got %0b expected 0 at row %0d", done, row); end
            out_ready = !(row == stall_row && stalls < stall_len);
            if (out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_t_q.size() > 0) void'(exp_t_q.pop_front());
                row++;
            end else stalls++;
            drain_cycles++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        exp_cycles = 32'(load_cycles + FL + drain_cycles);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: got done=%0b busy=%0b expected done=1 busy=0", done, busy);
        end
        n_checks++;
        if (cycles_count !== exp_cycles) begin
            n_fail++;
            $display("FAIL cycles_count: got %0d expected %0d", cycles_count, exp_cycles);
        end
        cc = cycles_count;
        out_ready = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || cycles_count !== exp_cycles) begin
            n_fail++;
            $display("FAIL after_done: got done=%0b cycles=%0d expected done=0 cycles=%0d", done, cycles_count, exp_cycles);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_flags: got busy=%0b in_ready=%0b out_valid=%0b done=%0b expected all 0",
                     tag, busy, in_ready, out_valid, done);
        end
        n_checks++;
        if (out_row !== '0 || out_row_idx !== 2'd0 || cycles_count !== 32'd0 || busy_t !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_data: got row=%h idx=%0d cycles=%0d busy_t=%0b expected all 0",
                     tag, out_row, out_row_idx, cycles_count, busy_t);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_latency();
        set_identity_job();
        run_job(4, 0, -1, 0, 1'b0, cc_plain);
    endtask

    task automatic test_bubbles();
        set_identity_job();
        run_job(4, 1, -1, 0, 1'b0, cc_bubble);
        n_checks++;
        if (cc_bubble !== cc_plain + 32'd4) begin
            n_fail++;
            $display("FAIL bubble_cycles: got %0d expected %0d", cc_bubble, cc_plain + 32'd4);
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < ROWS; i++) xm[k][i] = 127;
            for (int j = 0; j < COLS; j++) wm[k][j] = 127;
        end
        run_job(4, 0, -1, 0, 1'b0, cc_tmp);
    endtask

    task automatic test_back_pressure();
        set_identity_job();
        run_job(4, 0, 1, 5, 1'b0, cc_tmp);
    endtask

    task automatic test_ignored_start();
        start = 1'b1;
        k_len = 16'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || cycles_count !== exp_cycles) begin
            n_fail++;
            $display("FAIL zero_k_start: got busy=%0b in_ready=%0b cycles=%0d expected 0/0/%0d",
                     busy, in_ready, cycles_count, exp_cycles);
        end
        in_valid = 1'b0;
        set_identity_job();
        run_job(4, 0, -1, 0, 1'b1, cc_tmp);
    endtask

    task automatic test_reset_mid_job();
        set_identity_job();
        start = 1'b1;
        k_len = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        drive_beat(0);
        @(posedge clk); #1;
        drive_beat(1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("midjob_reset");
        @(posedge clk); #1;
        check_reset_outputs("midjob_hold");
        @(negedge clk);
        rst_n = 1'b1;
        run_job(4, 0, -1, 0, 1'b0, cc_tmp);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int k;
            k = $urandom_range(1, 8);
            for (int kk = 0; kk < k; kk++) begin
                for (int i = 0; i < ROWS; i++) xm[kk][i] = int'($urandom_range(0, 255)) - 128;
                for (int j = 0; j < COLS; j++) wm[kk][j] = int'($urandom_range(0, 255)) - 128;
            end
            run_job(k, 2, $urandom_range(0, 3), $urandom_range(0, 3), 1'(n % 2), cc_tmp);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bubbles();
        test_saturation();
        test_back_pressure();
        test_ignored_start();
        test_reset_mid_job();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
